uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the UART controller's receive path. It captures every byte the UART presents on rx_data_valid, together with its parity-error flag. The UART receive path has no backpressure, so this block absorbs bursts and presents the bytes to the system through a valid/ready interface. It also reports fill level, almost-full and a sticky overflow flag for bytes it had to drop.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path types and default sizing.
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH = 16;

    typedef struct packed {
        logic                   error;
        logic [UART_DATA_W-1:0] data;
    } uart_rx_word_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    parameter type         word_t = uart_rx_word_t,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  word_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output word_t             rdata
);

    word_t mem [DEPTH];

    // Contents are deliberately not reset; pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART: absorbs bytes without backpressure, FWFT valid/ready out.
// Optional synchronous flush port when UART_RX_FIFO_FLUSH_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = UART_RX_FIFO_DEPTH,
    parameter int unsigned DATA_W       = UART_DATA_W,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_data_valid,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_data_error,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_error,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     overflow_clear
`ifdef UART_RX_FIFO_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    typedef struct packed {
        logic              error;
        logic [DATA_W-1:0] data;
    } rx_word_t;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    logic [PTR_W-1:0] wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [PTR_W-1:0] level_n;
    logic             empty_n;
    logic             full_n;
    logic             almost_full_n;
    logic             overflow_n;

    logic             flush_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;

    rx_word_t         wr_word;
    rx_word_t         head_word;

`ifdef UART_RX_FIFO_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Handshake decode; a full FIFO still accepts a byte when the head leaves the same cycle.
    assign pop_c  = m_valid && m_ready;
    assign push_c = rx_data_valid && (!full || pop_c) && !flush_c;
    assign drop_c = rx_data_valid && full && !pop_c && !flush_c;

    assign wr_word = '{error: rx_data_error, data: rx_data};

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .word_t (rx_word_t)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (wr_word),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (head_word)
    );

    // Next pointers and status; flags derive from the next pointers so they never disagree.
    always_comb begin
        wr_ptr_n      = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_n      = rd_ptr_q + PTR_W'(pop_c);
        overflow_n    = overflow;

        if (flush_c) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end

        if (drop_c) begin
            overflow_n = 1'b1;
        end else if (overflow_clear) begin
            overflow_n = 1'b0;
        end

        level_n       = wr_ptr_n - rd_ptr_n;
        empty_n       = (wr_ptr_n == rd_ptr_n);
        full_n        = (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0]) &&
                        (wr_ptr_n[ADDR_W] != rd_ptr_n[ADDR_W]);
        almost_full_n = (level_n >= PTR_W'(AFULL_THRESH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            m_valid     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_n;
            rd_ptr_q    <= rd_ptr_n;
            level       <= level_n;
            empty       <= empty_n;
            full        <= full_n;
            almost_full <= almost_full_n;
            m_valid     <= !empty_n;
            overflow    <= overflow_n;
        end
    end

    // Head is presented as zero while nothing is stored.
    assign m_data  = m_valid ? head_word.data  : '0;
    assign m_error = m_valid ? head_word.error : 1'b0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue model checked every cycle plus directed literal checks.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic       rx_data_error;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_error;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       overflow_clear;
    logic       flush_in;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    logic [8:0] mq[$];
    logic       m_ovf;
    logic       mdl_pop;
    logic       mdl_full;
    logic [8:0] got[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH        (DEPTH),
        .DATA_W       (8),
        .AFULL_THRESH (AFT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data_valid  (rx_data_valid),
        .rx_data        (rx_data),
        .rx_data_error  (rx_data_error),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_error        (m_error),
        .level          (level),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
`ifdef UART_RX_FIFO_FLUSH_EN
        ,
        .flush          (flush_in)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic e,
                       input logic r, input logic c);
        rx_data_valid  = v;
        rx_data        = d;
        rx_data_error  = e;
        m_ready        = r;
        overflow_clear = c;
        @(posedge clk);
        #1;
    endtask

    // Reference: a plain queue of {error,data} plus a sticky drop bit.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            mdl_pop  = (mq.size() > 0) && m_ready;
            mdl_full = (mq.size() == DEPTH);
            if (flush_in) begin
                mq.delete();
            end else begin
                if (rx_data_valid && mdl_full && !mdl_pop) m_ovf = 1'b1;
                else if (overflow_clear)                   m_ovf = 1'b0;
                if (mdl_pop) void'(mq.pop_front());
                if (rx_data_valid && (!mdl_full || mdl_pop))
                    mq.push_back({rx_data_error, rx_data});
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid",     32'(m_valid),     32'(mq.size() != 0));
            chk("m_data",      32'(m_data),      (mq.size() != 0) ? 32'(mq[0][7:0]) : 32'h0);
            chk("m_error",     32'(m_error),     (mq.size() != 0) ? 32'(mq[0][8])   : 32'h0);
            chk("level",       32'(level),       32'(mq.size()));
            chk("empty",       32'(empty),       32'(mq.size() == 0));
            chk("full",        32'(full),        32'(mq.size() == DEPTH));
            chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFT));
            chk("overflow",    32'(overflow),    32'(m_ovf));
        end
        if (m_valid && m_ready) got.push_back({m_error, m_data});
    end

    initial begin
        reset = 1'b1;
        rx_data_valid = 1'b0; rx_data = 8'h0; rx_data_error = 1'b0;
        m_ready = 1'b0; overflow_clear = 1'b0; flush_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        cmp_en = 1'b1;

        // Reset in the middle of a cycle with 5 bytes stored
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_mvalid", 32'(m_valid), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        got.delete();
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5_head", 32'(m_data), 32'hA5);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("a5_popped", 32'(got.size() == 1 && got[0] == 9'h0A5), 32'd1);

        // Ordering with parity flags and FWFT latency
        got.delete();
        chk("ord_idle_mvalid", 32'(m_valid), 32'd0);
        cyc(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        chk("ord_first_mvalid", 32'(m_valid), 32'd1);
        chk("ord_first_data", 32'(m_data), 32'h11);
        cyc(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("ord_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("ord_0", 32'(got[0]), 32'h011);
            chk("ord_1", 32'(got[1]), 32'h122);
            chk("ord_2", 32'(got[2]), 32'h033);
        end

        // Fill to full, watching almost_full cross the threshold
        got.delete();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 10) chk("afull_at_11", 32'(almost_full), 32'd0);
            if (i == 11) chk("afull_at_12", 32'(almost_full), 32'd1);
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_level", 32'(level), 32'd16);

        // Overflow: drop, drop+clear, clear alone
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("drop_level", 32'(level), 32'd16);
        chk("drop_ovf",   32'(overflow), 32'd1);
        cyc(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
        chk("drop_clr_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Drain 8, refill across the pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("half_level", 32'(level), 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        chk("refull", 32'(full), 32'd1);

        // Push and pop together while full
        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_ovf",   32'(overflow), 32'd0);
        chk("pp_full",  32'(full), 32'd1);
        for (int i = 0; i < 18; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("wrap_count", 32'(got.size()), 32'd25);
        for (int i = 0; i < 25; i++) begin
            if (got.size() > i)
                chk($sformatf("wrap_%0d", i), 32'(got[i]), (i < 24) ? 32'(i) : 32'h055);
        end
        chk("drained_empty", 32'(empty), 32'd1);

`ifdef UART_RX_FIFO_FLUSH_EN
        // Flush with 7 entries and a same-cycle push
        got.delete();
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        flush_in = 1'b1;
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        flush_in = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("flush_no_out", 32'(got.size()), 32'd0);
`endif

        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
